// File: rtl/spi_tx_feeder_pkg.sv
// Shared types and helpers for the SPI transmit feeder.
package spi_feeder_pkg;

  localparam int unsigned DW_DEFAULT = 12;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StGap
  } feeder_state_e;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_tx_feeder_if.sv
// System-side and SPI-side signal bundle of the transmit feeder.
interface spi_tx_feeder_if
  import spi_feeder_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 8
) ();

  localparam int unsigned LW = ptr_w(DEPTH);

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic          newd;
  logic [DW-1:0] din;
  logic          done;
  logic [DW-1:0] dout;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;

  // Environment side: writes words, answers transfers, clears errors.
  modport master (
    output wr_en, wr_data, done, dout, clr_err,
    input  full, level, overflow, newd, din, rx_data, rx_valid, busy, timeout_err
  );

  // Feeder side.
  modport slave (
    input  wr_en, wr_data, done, dout, clr_err,
    output full, level, overflow, newd, din, rx_data, rx_valid, busy, timeout_err
  );

endinterface

// File: rtl/spi_word_fifo.sv
// Circular word FIFO with show-ahead read; pointers carry an extra wrap bit.
module spi_word_fifo
  import spi_feeder_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           rdata,
  output logic                    full,
  output logic                    empty,
  output logic [ptr_w(DEPTH)-1:0] level
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (level == PW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot this cycle, so a push while full is still taken.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Storage: no reset, emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Buffers words and issues them one at a time to the SPI master via newd/din,
// returning each received word with a one-cycle valid strobe.
module spi_tx_feeder
  import spi_feeder_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic            clk,
  input logic            rst,
  spi_tx_feeder_if.slave bus
);

  localparam int unsigned LW  = ptr_w(DEPTH);
  localparam int unsigned HCW = $clog2(HOLD_CYC) + 1;
  localparam int unsigned GCW = $clog2(GAP_CYC) + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC) + 1;

  feeder_state_e  state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           newd_q, newd_d;
  logic [DW-1:0]  din_q, din_d;
  logic [DW-1:0]  rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           overflow_q, timeout_err_q;
  logic           ovf_set, tmo_set;

  logic           fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_head;
  logic [LW-1:0]  fifo_level;

  spi_word_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.wr_en),
    .pop  (fifo_pop),
    .wdata(bus.wr_data),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  // A write refused for lack of space; a same-cycle pop makes room.
  assign ovf_set = bus.wr_en & fifo_full & ~fifo_pop;

  // Transfer sequencing: launch, hold newd, await done or timeout, then gap.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    newd_d     = newd_q;
    din_d      = din_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    fifo_pop   = 1'b0;
    tmo_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          din_d    = fifo_head;
          newd_d   = 1'b1;
          hold_d   = HCW'(HOLD_CYC - 1);
          tmo_d    = TCW'(TIMEOUT_CYC - 1);
          state_d  = StLaunch;
        end
      end
      StLaunch, StWaitDone: begin
        if (bus.done) begin
          newd_d     = 1'b0;
          rx_data_d  = bus.dout;
          rx_valid_d = 1'b1;
          gap_d      = GCW'(GAP_CYC - 1);
          state_d    = StGap;
        end else if (tmo_q == '0) begin
          newd_d  = 1'b0;
          tmo_set = 1'b1;
          gap_d   = GCW'(GAP_CYC - 1);
          state_d = StGap;
        end else begin
          tmo_d = tmo_q - 1'b1;
          if (state_q == StLaunch) begin
            if (hold_q == '0) begin
              newd_d  = 1'b0;
              state_d = StWaitDone;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs; a new error beats clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      newd_q        <= 1'b0;
      din_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      newd_q        <= newd_d;
      din_q         <= din_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overflow_q    <= ovf_set | (overflow_q & ~bus.clr_err);
      timeout_err_q <= tmo_set | (timeout_err_q & ~bus.clr_err);
    end
  end

  assign bus.full        = fifo_full;
  assign bus.level       = fifo_level;
  assign bus.overflow    = overflow_q;
  assign bus.newd        = newd_q;
  assign bus.din         = din_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Bench for spi_tx_feeder: directed scenarios plus random traffic, all checked
// every cycle against a timestamp-based transaction model.
module tb_spi_tx_feeder;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int          HOLD  = 16;
  localparam int          GAP   = 4;
  localparam int          TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_tx_feeder_if #(.DW(DW), .DEPTH(DEPTH)) ifc ();

  spi_tx_feeder #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .HOLD_CYC   (HOLD),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending words, plus launch/end timestamps of the word in flight.
  logic [DW-1:0] q[$];
  int            n, t_launch, t_end;
  bit            m_active, m_ended, m_rxv, m_ovf, m_tmo;
  logic [DW-1:0] m_din, m_rx;

  always @(posedge clk or negedge rst) begin
    bit pop, ovf_set, tmo_set;
    if (!rst) begin
      q.delete();
      n = 0; t_launch = 0; t_end = 0;
      m_active = 0; m_ended = 0; m_rxv = 0; m_ovf = 0; m_tmo = 0;
      m_din = '0; m_rx = '0;
    end else begin
      n++;
      pop = 0; tmo_set = 0; m_rxv = 0;
      if (!m_active) begin
        pop = (q.size() > 0);
      end else if (!m_ended) begin
        if (ifc.done) begin
          m_ended = 1; t_end = n; m_rx = ifc.dout; m_rxv = 1;
        end else if (n - t_launch >= TMO) begin
          m_ended = 1; t_end = n; tmo_set = 1;
        end
      end else if (n - t_end >= GAP) begin
        m_active = 0;
      end
      ovf_set = ifc.wr_en && (q.size() == DEPTH) && !pop;
      if (pop) begin
        m_din = q.pop_front();
        m_active = 1; m_ended = 0; t_launch = n;
      end
      if (ifc.wr_en && !ovf_set) q.push_back(ifc.wr_data);
      m_ovf = ovf_set || (m_ovf && !ifc.clr_err);
      m_tmo = tmo_set || (m_tmo && !ifc.clr_err);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("newd",     ifc.newd, m_active && !m_ended && (n - t_launch) < HOLD);
      check("din",      ifc.din, m_din);
      check("level",    ifc.level, q.size());
      check("full",     ifc.full, q.size() == DEPTH);
      check("overflow", ifc.overflow, m_ovf);
      check("rx_valid", ifc.rx_valid, m_rxv);
      check("rx_data",  ifc.rx_data, m_rx);
      check("busy",     ifc.busy, m_active);
      check("timeout",  ifc.timeout_err, m_tmo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    ifc.wr_en = 1'b1;
    ifc.wr_data = d;
    tick();
    ifc.wr_en = 1'b0;
  endtask

  task automatic wait_newd();
    int k = 0;
    while (ifc.newd !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    check("newd_wait", ifc.newd, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ifc.busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check("idle_wait", ifc.busy, 0);
  endtask

  // Wait for a launch, check the word, answer with done after dly cycles.
  task automatic serve(input logic [DW-1:0] exp_din, input int dly);
    wait_newd();
    check("order", ifc.din, exp_din);
    repeat (dly - 1) tick();
    ifc.done = 1'b1;
    ifc.dout = 12'($urandom);
    tick();
    ifc.done = 1'b0;
  endtask

  initial begin
    int cnt;
    ifc.wr_en = 1'b0; ifc.wr_data = '0; ifc.done = 1'b0; ifc.dout = '0; ifc.clr_err = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", ifc.level, 0);
    check("rst_full", ifc.full, 0);
    check("rst_newd", ifc.newd, 0);
    check("rst_din", ifc.din, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_rx", {ifc.rx_valid, ifc.rx_data}, 0);
    check("rst_flags", {ifc.overflow, ifc.timeout_err}, 0);
    rst = 1'b1;
    tick();

    // Single word, done 40 cycles after launch.
    push(12'h2A5);
    check("t1_level", ifc.level, 1);
    check("t1_newd_lat", ifc.newd, 0);
    tick();
    check("t1_newd", ifc.newd, 1);
    check("t1_din", ifc.din, 12'h2A5);
    repeat (15) tick();
    check("t1_hold_last", ifc.newd, 1);
    tick();
    check("t1_hold_end", ifc.newd, 0);
    repeat (23) tick();
    ifc.done = 1'b1; ifc.dout = 12'h15A;
    tick();
    ifc.done = 1'b0;
    check("t1_rxv", ifc.rx_valid, 1);
    check("t1_rxd", ifc.rx_data, 12'h15A);
    tick();
    check("t1_rxv_once", ifc.rx_valid, 0);
    repeat (2) tick();
    check("t1_gap_busy", ifc.busy, 1);
    tick();
    check("t1_idle", ifc.busy, 0);

    // Burst behind a filler transfer, push/pop while full, then overflow.
    wait_idle();
    push(12'h0F0);
    wait_newd();
    for (int i = 1; i <= 8; i++) push(12'(i));
    check("b_level8", ifc.level, 8);
    check("b_full", ifc.full, 1);
    ifc.done = 1'b1;
    tick();
    ifc.done = 1'b0;
    repeat (4) tick();
    check("b_idle_full", {ifc.busy, ifc.level}, {1'b0, 4'd8});
    push(12'h0AB);
    check("pp_level", ifc.level, 8);
    check("pp_ovf", ifc.overflow, 0);
    check("pp_din", ifc.din, 12'h001);
    push(12'h009);
    check("ovf_set", ifc.overflow, 1);
    check("ovf_level", ifc.level, 8);
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    check("ovf_clr", ifc.overflow, 0);
    for (int i = 1; i <= 8; i++) serve(12'(i), int'($urandom_range(1, 40)));
    serve(12'h0AB, 7);

    // Timeout, followed by the next queued word.
    wait_idle();
    push(12'h3C3);
    push(12'h0C3);
    check("to_launch", {ifc.newd, ifc.din}, {1'b1, 12'h3C3});
    repeat (63) tick();
    check("to_before", ifc.timeout_err, 0);
    tick();
    check("to_set", ifc.timeout_err, 1);
    check("to_no_rxv", ifc.rx_valid, 0);
    repeat (5) tick();
    check("to_next", {ifc.newd, ifc.din}, {1'b1, 12'h0C3});
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    check("to_clr", ifc.timeout_err, 0);
    serve(12'h0C3, 10);

    // Early done at hold cycle 5.
    wait_idle();
    push(12'h111);
    tick();
    repeat (4) tick();
    check("ed_newd", ifc.newd, 1);
    ifc.done = 1'b1; ifc.dout = 12'h777;
    tick();
    ifc.done = 1'b0;
    check("ed_drop", ifc.newd, 0);
    check("ed_rx", {ifc.rx_valid, ifc.rx_data}, {1'b1, 12'h777});
    tick();
    check("ed_once", ifc.rx_valid, 0);

    // Reset during WAIT_DONE with three words queued.
    wait_idle();
    push(12'h222);
    tick();
    repeat (20) tick();
    push(12'h301); push(12'h302); push(12'h303);
    check("rs_level", ifc.level, 3);
    rst = 1'b0;
    #1;
    check("rs_newd", ifc.newd, 0);
    check("rs_level0", ifc.level, 0);
    check("rs_busy", ifc.busy, 0);
    repeat (2) tick();
    rst = 1'b1;
    cnt = 0;
    repeat (30) begin
      tick();
      if (ifc.newd) cnt++;
    end
    check("rs_no_newd", cnt, 0);

    // Random traffic, including done pulses in GAP/IDLE and clears.
    for (int c = 0; c < 1500; c++) begin
      ifc.wr_en   = ($urandom_range(0, 3) == 0);
      ifc.wr_data = 12'($urandom);
      ifc.done    = ($urandom_range(0, 15) == 0);
      ifc.dout    = 12'($urandom);
      ifc.clr_err = ($urandom_range(0, 31) == 0);
      tick();
    end
    ifc.wr_en = 1'b0; ifc.done = 1'b0; ifc.clr_err = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_feeder.md
Name: spi_tx_feeder

Overview:
- Upstream of the SPI top; buffers 12-bit words from the system side and issues them one at a time to the SPI master through its newd/din interface.
- Waits for the master's done pulse, captures the returned dout word, and returns it with a valid strobe.
- Adds a hold window for newd, an inter-transfer gap, a done timeout and overflow detection.

Parameters:
- DW, 12, data word width; matches SPI din/dout.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- HOLD_CYC, 16, clk cycles newd stays high per launch; covers one SPI sync_clock period.
- GAP_CYC, 4, idle clk cycles between the end of one transfer and the next launch.
- TIMEOUT_CYC, 4096, max clk cycles to wait for done after launch.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  DW  word to transmit.
- full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set on wr_en while full.
- newd  out  1  to SPI top: new-data request.
- din  out  DW  to SPI top: word being sent.
- done  in  1  from SPI top: transfer complete, 1-cycle pulse.
- dout  in  DW  from SPI top: received word, valid when done=1.
- rx_data  out  DW  captured dout.
- rx_valid  out  1  one-cycle strobe with rx_data.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; done not seen within TIMEOUT_CYC.
- clr_err  in  1  synchronous clear of overflow and timeout_err.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, level=0, full=0, newd=0, din=0, rx_data=0, rx_valid=0, busy=0, overflow=0, timeout_err=0, FSM=IDLE. Asserting reset mid-transfer drops newd immediately. No pending word survives reset.
- FIFO: circular, with read and write pointers one bit wider than the address.
  - Push when wr_en=1 and not full.
  - wr_en=1 while full: word dropped, overflow=1.
  - A push and a pop in the same cycle is legal at any level, including full; level is unchanged. On the full-and-pop case the push is accepted.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If the FIFO is non-empty: pop the head into din, set newd=1, load the hold counter with HOLD_CYC-1, load the timeout counter, go to LAUNCH.
  - newd rises in the cycle after the FIFO becomes non-empty (one-cycle latency from write to newd).
- LAUNCH:
  - newd=1 and din stable.
  - Hold counter reaches 0: newd=0, go to WAIT_DONE.
  - done=1 in LAUNCH: treat as completion (newd=0, capture, go to GAP).
- WAIT_DONE:
  - din holds its value.
  - done=1: rx_data<=dout, rx_valid=1 on the next cycle for exactly one cycle, go to GAP.
  - Timeout counter expires first: timeout_err=1, no rx_valid, go to GAP.
  - The timeout counter runs from launch through LAUNCH and WAIT_DONE.
- GAP: count GAP_CYC cycles, then go to IDLE. done pulses arriving in GAP or IDLE are ignored and produce no rx_valid.
- Only one word is in flight at a time; din changes only on a pop from IDLE.
- clr_err=1: clears both sticky flags. A new error in the same cycle wins and the flag stays set.
- Counters saturate; no wrap-around. Pointer wrap is handled by the extra MSB.

Decomposition:
- Package spi_feeder_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT_DONE, GAP);
  - the DW default constant;
  - a localparam function for pointer width.
- One sub-module, spi_word_fifo (parameterised DW/DEPTH, ports: push, pop, data in/out, full, empty, level). The FSM and counters live in spi_tx_feeder.

Test Plan:
- Single word: write 12'h2A5 → newd high for 16 cycles with din=12'h2A5; drive done with dout=12'h15A 40 cycles after launch → rx_valid pulses once with rx_data=12'h15A; busy low 4 cycles later.
- Burst: write 8 words 1..8 back-to-back → full=1 after the 8th (level=8). A 9th write (12'h009) → overflow=1, word dropped. Exactly 8 transfers occur in order 1..8, each separated by at least 4 idle cycles.
- Simultaneous push/pop: FIFO full, and wr_en is asserted in the cycle the FSM pops → level stays 8, overflow stays 0.
- Timeout: TIMEOUT_CYC=64, no done driven → timeout_err=1 at cycle 64 after launch, no rx_valid. The next queued word launches after GAP. clr_err → timeout_err=0.
- Early done: done asserted at hold cycle 5 → newd drops the next cycle, rx_valid fires once, hold period is truncated.
- Reset mid-transfer: rst=0 during WAIT_DONE with 3 words queued → newd=0, level=0, busy=0 immediately. After release with no writes, no newd appears.
